// File: rtl/send_buf_if.sv
// send_buf_if: upstream write, credit reload and send_frame read signals of send_buf_burst
interface send_buf_if #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 10,
  parameter int CREDIT_W = 32
);
  logic                sfp_wr_en;
  logic [DATA_W-1:0]   sfp_wr_data;
  logic                next_buff_vaild;
  logic [CREDIT_W-1:0] next_buff_statue;
  logic                tx_allow;
  logic                tx_rden;
  logic [DATA_W-1:0]   tx_rddata;
  logic                tx_rdvalid;
  logic                send_idle;
  logic [ADDR_W:0]     fifo_level;
  logic [CREDIT_W-1:0] credit;
  modport master (
    output sfp_wr_en, sfp_wr_data, next_buff_vaild, next_buff_statue, tx_rden,
    input  tx_allow, tx_rddata, tx_rdvalid, send_idle, fifo_level, credit
  );
  modport slave (
    input  sfp_wr_en, sfp_wr_data, next_buff_vaild, next_buff_statue, tx_rden,
    output tx_allow, tx_rddata, tx_rdvalid, send_idle, fifo_level, credit
  );
endinterface

// File: rtl/send_buf_burst.sv
// send_buf_burst: credit-tracked transmit FIFO granting fixed-length bursts; SEND_BUF_STAT_EN adds drop/stall counters
module send_buf_burst #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 10,
  parameter int CREDIT_W    = 32,
  parameter int CREDIT_INIT = 1024,
  parameter int BURST_LEN   = 16,
  parameter int GAP_CYC     = 4,
  parameter int AF_MARGIN   = 16
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  send_buf_if.slave     bus
`ifdef SEND_BUF_STAT_EN
  ,
  output logic [31:0]   stat_drop_cnt,
  output logic [31:0]   stat_stall_cnt
`endif
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int LW    = ADDR_W + 1;
  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]       level;
  logic [CREDIT_W-1:0] credit, credit_nxt;
  logic [LW-1:0]       burst_cnt;
  logic [31:0]         gap_cnt;
  logic [DATA_W-1:0]   rddata;
  logic                rdvalid, vaild_d, rise, allow, full, wr_acc, rd_acc;
  logic                lvl_ok, crd_ok, burst_end, gap_end;
  assign full    = level == LW'(DEPTH);
  assign allow   = state == BURST;
  assign wr_acc  = bus.sfp_wr_en && !full;
  assign rd_acc  = bus.tx_rden && allow && level != '0 && credit != '0;
  assign rise    = bus.next_buff_vaild && !vaild_d;
  assign lvl_ok  = level >= LW'(BURST_LEN);
  assign crd_ok  = credit >= CREDIT_W'(BURST_LEN);
  assign gap_end = gap_cnt + 32'd1 >= 32'(GAP_CYC);
  // a reload landing on the same cycle as a read still consumes one credit
  always_comb begin
    credit_nxt = rise && rd_acc ? (bus.next_buff_statue == '0 ? '0 : bus.next_buff_statue - CREDIT_W'(1))
               : rise           ? bus.next_buff_statue
               : rd_acc         ? credit - CREDIT_W'(1)
               :                  credit;
    burst_end  = (rd_acc && burst_cnt == LW'(BURST_LEN - 1)) || credit_nxt == '0;
    state_nxt  = state == IDLE  ? (lvl_ok && crd_ok ? BURST : IDLE)
               : state == BURST ? (burst_end ? GAP : BURST)
               :                  (gap_end ? IDLE : GAP);
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= state == IDLE ? '0 : burst_cnt + LW'(allow && rd_acc);
      gap_cnt   <= state == GAP ? gap_cnt + 32'd1 : '0;
    end
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rddata  <= '0;
      rdvalid <= 1'b0;
      credit  <= CREDIT_W'(CREDIT_INIT);
      vaild_d <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + ADDR_W'(wr_acc);
      rd_ptr  <= rd_ptr + ADDR_W'(rd_acc);
      level   <= level + LW'(wr_acc) - LW'(rd_acc);
      rdvalid <= rd_acc;
      credit  <= credit_nxt;
      vaild_d <= bus.next_buff_vaild;
      if (rd_acc) rddata <= mem[rd_ptr];
    end
  end
  always_ff @(posedge ap_clk) begin
    if (wr_acc && !ap_rst) mem[wr_ptr] <= bus.sfp_wr_data;
  end
`ifdef SEND_BUF_STAT_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      stat_drop_cnt  <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (bus.sfp_wr_en && full && stat_drop_cnt != '1) stat_drop_cnt <= stat_drop_cnt + 32'd1;
      if (state == IDLE && lvl_ok && !crd_ok && stat_stall_cnt != '1) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif
  assign bus.tx_allow   = allow;
  assign bus.tx_rddata  = rddata;
  assign bus.tx_rdvalid = rdvalid;
  assign bus.fifo_level = level;
  assign bus.credit     = credit;
  assign bus.send_idle  = level < LW'(DEPTH - AF_MARGIN);
endmodule

// File: tb/tb_send_buf_burst.sv
// tb_send_buf_burst: directed scoreboard bench for send_buf_burst at default parameters
module tb_send_buf_burst;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;
  send_buf_if #(.DATA_W(64), .ADDR_W(10), .CREDIT_W(32)) bus ();
`ifdef SEND_BUF_STAT_EN
  logic [31:0] drop_cnt, stall_cnt;
  int          s0;
`endif
  send_buf_burst dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus.slave)
`ifdef SEND_BUF_STAT_EN
    ,
    .stat_drop_cnt  (drop_cnt),
    .stat_stall_cnt (stall_cnt)
`endif
  );
  int          total = 0, passed = 0, rd_cnt = 0;
  logic [63:0] exp_q [$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask
  task automatic nstep();
    @(negedge ap_clk);
    #1;
  endtask
  task automatic wr(input logic [63:0] d, input bit acc);
    bus.sfp_wr_en   = 1'b1;
    bus.sfp_wr_data = d;
    if (acc) exp_q.push_back(d);
    step();
    bus.sfp_wr_en = 1'b0;
  endtask
  task automatic run(input logic v, output int n);
    n = 0;
    while (bus.tx_allow === v && n < 200) begin
      n++;
      nstep();
    end
  endtask
  always @(negedge ap_clk) begin
    if (bus.tx_rdvalid === 1'b1) begin
      rd_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL rd_data: got %0d, expected no read (scoreboard empty)", bus.tx_rddata);
      end else chk("rd_data", bus.tx_rddata, exp_q.pop_front());
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    int n, h1, lo, h2, base;
    bus.sfp_wr_en = 0; bus.sfp_wr_data = 0; bus.next_buff_vaild = 0;
    bus.next_buff_statue = 0; bus.tx_rden = 0;
    repeat (2) step();
    ap_rst = 0;
    chk("rst_allow", bus.tx_allow, 0);
    chk("rst_rdvalid", bus.tx_rdvalid, 0);
    chk("rst_rddata", bus.tx_rddata, 0);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_send_idle", bus.send_idle, 1);
    chk("rst_credit", bus.credit, 1024);
    // threshold hold-off then the first burst
    bus.tx_rden = 1;
    for (int i = 0; i < 15; i++) wr(64'(i), 1);
    repeat (5) nstep();
    chk("holdoff_allow", bus.tx_allow, 0);
    chk("holdoff_level", bus.fifo_level, 15);
    wr(64'd15, 1);
    nstep();
    run(1'b0, n);
    chk("allow_within_2", 64'(n <= 2), 1);
    base = rd_cnt;
    run(1'b1, n);
    chk("burst1_allow_cycles", 64'(n), 16);
    chk("burst1_reads", 64'(rd_cnt - base), 16);
    chk("burst1_credit", bus.credit, 1008);
    nstep();
    chk("gap_rdvalid", bus.tx_rdvalid, 0);
    chk("rddata_hold", bus.tx_rddata, 15);
    // back-to-back bursts measure the idle gap
    bus.tx_rden = 0;
    for (int i = 0; i < 32; i++) wr(64'(100 + i), 1);
    nstep();
    run(1'b0, n);
    chk("burst2_ready", bus.tx_allow, 1);
    bus.tx_rden = 1;
    run(1'b1, h1);
    run(1'b0, lo);
    run(1'b1, h2);
    chk("burst2_len", 64'(h1), 16);
    chk("gap_low_cycles", 64'(lo), 5);
    chk("burst3_len", 64'(h2), 16);
    chk("burst3_credit", bus.credit, 976);
    chk("burst3_level", bus.fifo_level, 0);
    // credit starvation
    bus.next_buff_vaild = 1; bus.next_buff_statue = 5;
    step();
    bus.next_buff_vaild = 0;
    chk("reload5_credit", bus.credit, 5);
    for (int i = 0; i < 40; i++) wr(64'(200 + i), 1);
    repeat (20) nstep();
    chk("starve_allow", bus.tx_allow, 0);
    chk("starve_level", bus.fifo_level, 40);
`ifdef SEND_BUF_STAT_EN
    s0 = int'(stall_cnt);
    repeat (3) nstep();
    chk("stall_cnt_delta", 64'(int'(stall_cnt) - s0), 3);
`endif
    bus.next_buff_vaild = 1; bus.next_buff_statue = 100;
    step();
    bus.next_buff_vaild = 0;
    nstep();
    run(1'b0, n);
    chk("reload100_allow", bus.tx_allow, 1);
    run(1'b1, n);
    bus.tx_rden = 0;
    chk("reload100_burst", 64'(n), 16);
    chk("reload100_credit", bus.credit, 84);
    chk("reload100_level", bus.fifo_level, 24);
    // mid-burst abort by reload to 2
    nstep();
    run(1'b0, n);
    chk("abort_start", bus.tx_allow, 1);
    base = rd_cnt;
    bus.tx_rden = 1;
    repeat (3) step();
    bus.tx_rden = 0; bus.next_buff_vaild = 1; bus.next_buff_statue = 2;
    step();
    bus.next_buff_vaild = 0; bus.tx_rden = 1;
    nstep();
    run(1'b1, n);
    chk("abort_extra_reads", 64'(n), 2);
    chk("abort_credit", bus.credit, 0);
    chk("abort_allow", bus.tx_allow, 0);
    chk("abort_level", bus.fifo_level, 19);
    chk("abort_total_reads", 64'(rd_cnt - base), 5);
    repeat (8) nstep();
    chk("abort_stays_off", bus.tx_allow, 0);
    bus.tx_rden = 0;
    // simultaneous reload+read, then write+read
    bus.next_buff_vaild = 1; bus.next_buff_statue = 200;
    step();
    bus.next_buff_vaild = 0;
    nstep();
    run(1'b0, n);
    chk("sim_allow", bus.tx_allow, 1);
    bus.tx_rden = 1; bus.next_buff_vaild = 1; bus.next_buff_statue = 50;
    step();
    bus.tx_rden = 0; bus.next_buff_vaild = 0;
    chk("rise_rd_credit", bus.credit, 49);
    chk("rise_rd_level", bus.fifo_level, 18);
    bus.tx_rden = 1;
    repeat (10) step();
    bus.tx_rden = 0;
    chk("pre_wr_rd_level", bus.fifo_level, 8);
    chk("pre_wr_rd_credit", bus.credit, 39);
    bus.tx_rden = 1;
    wr(64'd300, 1);
    bus.tx_rden = 0;
    chk("wr_rd_level", bus.fifo_level, 8);
    chk("wr_rd_credit", bus.credit, 38);
    // fill to full, overflow, then reset mid-burst
    for (int i = 0; i < 1016; i++) begin
      wr(64'(1000 + i), 1);
      if (i == 998) chk("send_idle_1007", bus.send_idle, 1);
      if (i == 999) chk("send_idle_1008", bus.send_idle, 0);
    end
    for (int i = 0; i < 3; i++) wr(64'hDEAD, 0);
    chk("full_level", bus.fifo_level, 1024);
    chk("full_send_idle", bus.send_idle, 0);
`ifdef SEND_BUF_STAT_EN
    chk("drop_cnt", drop_cnt, 3);
`endif
    chk("full_allow", bus.tx_allow, 1);
    bus.tx_rden = 1;
    repeat (2) step();
    ap_rst = 1;
    step();
    ap_rst = 0; bus.tx_rden = 0;
    exp_q.delete();
    chk("midrst_level", bus.fifo_level, 0);
    chk("midrst_allow", bus.tx_allow, 0);
    chk("midrst_credit", bus.credit, 1024);
    chk("midrst_rdvalid", bus.tx_rdvalid, 0);
    chk("midrst_send_idle", bus.send_idle, 1);
    repeat (3) nstep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
